// File: rtl/ethhelper_pkg.sv
// rtl/ethhelper_pkg.sv - shared arbiter state type, default widths and index-width helper
package ethhelper_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ    = 5;
    localparam int DEF_DATA_WIDTH = 128;
    localparam int DEF_TIMEOUT    = 1024;
    localparam int DEF_CNT_WIDTH  = 32;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_arbiter_if.sv
// rtl/stream_arbiter_if.sv - requester beats in, merged stream out
interface stream_arbiter_if import ethhelper_pkg::*; #(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_in_progress;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;

    logic [DATA_WIDTH-1:0]         m_axis_tdata;
    logic                          m_axis_tvalid;
    logic                          m_axis_tlast;
    logic                          m_axis_tready;

    // master is the arbiter side, slave is the requesters plus downstream sink
    modport master (
        input  req_valid, req_in_progress, req_last, req_data, m_axis_tready,
        output req_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        output req_valid, req_in_progress, req_last, req_data, m_axis_tready,
        input  req_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

endinterface

// File: rtl/stream_arbiter_rr_pick.sv
// rtl/stream_arbiter_rr_pick.sv - combinational round-robin pick starting after ptr
module rr_pick import ethhelper_pkg::*; #(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [IDX_W-1:0]   grant_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        cand         = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found              = 1'b1;
                grant_onehot[cand] = 1'b1;
                grant_idx          = cand;
            end
        end
    end

endmodule

// File: rtl/stream_arbiter.sv
// rtl/stream_arbiter.sv - packet-granular round-robin merge of requester streams
module stream_arbiter import ethhelper_pkg::*; #(
    parameter  int NUM_REQ    = DEF_NUM_REQ,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int TIMEOUT    = DEF_TIMEOUT,
    parameter  int CNT_WIDTH  = DEF_CNT_WIDTH,
    localparam int IDX_W      = idx_width(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 resetn,
    stream_arbiter_if.master     bus,
    output logic [IDX_W-1:0]     grant_id,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] pkt_count,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam int STALL_W = $clog2(TIMEOUT + 1);

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     last_owner_q, last_owner_d;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic [CNT_WIDTH-1:0] pkt_q, pkt_d;
    logic [CNT_WIDTH-1:0] err_q, err_d;

    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]     pick_idx;
    logic                 xfer;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req          (bus.req_valid),
        .ptr          (last_owner_q),
        .grant_onehot (pick_onehot),
        .grant_idx    (pick_idx)
    );

    // Owner's beat is routed straight through so the stream adds no latency
    always_comb begin
        bus.m_axis_tdata  = '0;
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tlast  = 1'b0;
        bus.req_ready     = '0;
        if (state_q == ST_GRANT) begin
            bus.m_axis_tdata       = bus.req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
            bus.m_axis_tvalid      = bus.req_valid[owner_q];
            bus.m_axis_tlast       = bus.req_last[owner_q];
            bus.req_ready[owner_q] = bus.m_axis_tready;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        stall_d      = stall_q;
        pkt_d        = pkt_q;
        err_d        = err_q;
        xfer         = bus.m_axis_tvalid && bus.m_axis_tready;
        case (state_q)
            ST_IDLE: begin
                if (|pick_onehot) begin
                    state_d = ST_GRANT;
                    owner_d = pick_idx;
                    stall_d = '0;
                end
            end
            ST_GRANT: begin
                if (xfer && bus.m_axis_tlast) begin
                    state_d      = ST_IDLE;
                    owner_d      = '0;
                    last_owner_d = owner_q;
                    stall_d      = '0;
                    pkt_d        = sat_inc(pkt_q);
                end else if (!bus.req_valid[owner_q] && !bus.req_in_progress[owner_q]) begin
                    state_d = ST_IDLE;
                    owner_d = '0;
                    stall_d = '0;
                    err_d   = sat_inc(err_q);
                end else if (xfer) begin
                    stall_d = '0;
                end else if (!bus.m_axis_tvalid) begin
                    // Backpressure with a beat waiting is not a stall, only a silent owner is
                    if (stall_q == STALL_W'(TIMEOUT - 1)) begin
                        state_d = ST_IDLE;
                        owner_d = '0;
                        stall_d = '0;
                        err_d   = sat_inc(err_q);
                    end else begin
                        stall_d = stall_q + STALL_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
            stall_q      <= '0;
            pkt_q        <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            stall_q      <= stall_d;
            pkt_q        <= pkt_d;
            err_q        <= err_d;
        end
    end

    assign busy      = (state_q == ST_GRANT);
    assign grant_id  = owner_q;
    assign pkt_count = pkt_q;
    assign err_count = err_q;

endmodule
